// File: rtl/uart_rx.sv
// UART receiver. It oversamples RX_IN by a run-time PRESCALE ratio and majority-votes three
// mid-bit samples for each bit. It checks the start bit, optional parity and the stop bit,
// then presents a good byte on P_DATA with a one-cycle DATA_VALID strobe.
//
// Ports:
//   CLK        oversampling clock, rising edge
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high, LSB first, already synchronous to CLK
//   PRESCALE   oversampling ratio (8, 16 or 32), captured at start detection
//   PAR_EN     1 = a parity bit follows the data bits, captured at start detection
//   PAR_TYP    0 = even, 1 = odd parity, captured at start detection
//   P_DATA     last good byte, held until the next good frame
//   DATA_VALID one-cycle strobe marking a new P_DATA
//   PAR_ERR    parity mismatch in the last frame
//   STP_ERR    stop bit sampled low in the last frame
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [5:0]            prescale_q;
  logic                  par_en_q, par_typ_q;
  logic [5:0]            edge_cnt_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [2:0]            smp_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_fail_q;

  logic [5:0] half;
  logic       bit_end, stop_pt, sampled, par_bad;
  logic       start_det, shift_en, par_chk, glitch, frame_done;

  assign half    = prescale_q >> 1;
  assign bit_end = (edge_cnt_q == prescale_q - 6'd1);
  // Stop decision is taken early to leave half a bit of slack for the next start bit.
  assign stop_pt = (edge_cnt_q == half + 6'd2);
  assign sampled = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign par_bad = sampled != ((^shift_q) ^ par_typ_q);

  always_comb begin
    state_d    = state_q;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    glitch     = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          start_det = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          if (sampled) begin
            glitch  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          par_chk = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (stop_pt) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      par_fail_q <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_det) begin
        prescale_q <= PRESCALE;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end

      // The detection cycle counts as edge 0 of the start bit, so START begins at edge 1.
      if (start_det) begin
        edge_cnt_q <= 6'd1;
      end else if (state_q == StIdle || frame_done || bit_end) begin
        edge_cnt_q <= '0;
      end else begin
        edge_cnt_q <= edge_cnt_q + 6'd1;
      end

      if (start_det) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + BitW'(1);
      end

      if (state_q != StIdle) begin
        if (edge_cnt_q == half - 6'd1) smp_q[0] <= RX_IN;
        if (edge_cnt_q == half)        smp_q[1] <= RX_IN;
        if (edge_cnt_q == half + 6'd1) smp_q[2] <= RX_IN;
      end

      if (shift_en) begin
        shift_q <= {sampled, shift_q[DATA_WIDTH-1:1]};
      end

      if (start_det) begin
        par_fail_q <= 1'b0;
      end else if (par_chk) begin
        par_fail_q <= par_bad;
      end

      DATA_VALID <= frame_done & ~par_fail_q & sampled;
      if (frame_done) begin
        PAR_ERR <= par_fail_q;
        STP_ERR <= ~sampled;
        if (!par_fail_q && sampled) begin
          P_DATA <= shift_q;
        end
      end else if (start_det || glitch) begin
        PAR_ERR <= 1'b0;
        STP_ERR <= 1'b0;
      end
    end
  end

endmodule
